// File: rtl/flash_clk_pkg.sv
// Shared types and helpers for the flash clock generator: per-channel
// configuration record, reset defaults and the accept-time coercion.
package flash_clk_pkg;

  localparam int CFG_W          = 8;
  localparam int PKG_DEF_PERIOD = 10;
  localparam int PKG_DEF_HIGH   = 5;

  localparam logic [CFG_W-1:0] PERIOD_MIN = CFG_W'(2);
  localparam logic [CFG_W-1:0] CNT_ONE    = CFG_W'(1);

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  // Period below 2 cannot produce a wave; a phase outside the period would
  // let the counter run past period-1, so it restarts from 0 instead.
  function automatic chan_cfg_t cfg_sanitize(input logic [CFG_W-1:0] period,
                                             input logic [CFG_W-1:0] high,
                                             input logic [CFG_W-1:0] phase);
    chan_cfg_t c;
    c.period = (period < PERIOD_MIN) ? PERIOD_MIN : period;
    c.high   = high;
    c.phase  = (phase >= c.period) ? '0 : phase;
    return c;
  endfunction

endpackage

// File: rtl/flash_clk_chan.sv
// One flash clock channel: period counter, active and shadow configuration,
// registered clock output and edge strobes.
module flash_clk_chan
  import flash_clk_pkg::*;
#(
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int DEF_HIGH   = PKG_DEF_HIGH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      enable,
  input  logic      sync_restart,
  input  logic      cfg_we,
  input  chan_cfg_t cfg_in,
  output logic      pending,
  output logic      flash_clk,
  output logic      rise_stb,
  output logic      fall_stb
);

  localparam chan_cfg_t DEF_CFG = '{period: CFG_W'(DEF_PERIOD),
                                    high:   CFG_W'(DEF_HIGH),
                                    phase:  '0};

  logic [CFG_W-1:0] cnt_q, cnt_d;
  chan_cfg_t        act_q, act_d;
  chan_cfg_t        shd_q, shd_d;
  logic             pend_d, out_d, rise_d, fall_d;
  logic             wrap, next_out;

  assign wrap     = (cnt_q == (act_q.period - CNT_ONE));
  assign next_out = (cnt_q < act_q.high);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pending;
    out_d  = flash_clk;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_restart) begin
      if (pending) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      cnt_d  = act_d.phase;
      out_d  = 1'b0;
      fall_d = flash_clk;
    end else if (!enable) begin
      // An idle channel has no period to finish, so a pending cfg lands now.
      if (pending) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      cnt_d = act_d.phase;
      out_d = 1'b0;
    end else begin
      cnt_d  = wrap ? '0 : (cnt_q + CNT_ONE);
      out_d  = next_out;
      rise_d = !flash_clk && next_out;
      fall_d = flash_clk && !next_out;
      if (wrap && pending) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end
    // The top only grants a write while nothing is pending, so this never
    // races with an apply above; a write on a boundary waits for the next one.
    if (cfg_we) begin
      shd_d  = cfg_in;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      act_q     <= DEF_CFG;
      shd_q     <= DEF_CFG;
      pending   <= 1'b0;
      flash_clk <= 1'b0;
      rise_stb  <= 1'b0;
      fall_stb  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pending   <= pend_d;
      flash_clk <= out_d;
      rise_stb  <= rise_d;
      fall_stb  <= fall_d;
    end
  end

endmodule

// File: rtl/flash_clk_gen.sv
// Multi-channel programmable flash clock generator: decodes configuration
// writes to per-channel shadow registers and fans out enable/sync.
module flash_clk_gen
  import flash_clk_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = CFG_W,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int DEF_HIGH   = PKG_DEF_HIGH,
  // One spare code above the channel range so an out-of-range target is
  // representable and can be refused.
  parameter int CH_W       = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync_restart,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [N_CH-1:0]  cfg_pending,
  output logic [N_CH-1:0]  flash_clk,
  output logic [N_CH-1:0]  rise_stb,
  output logic [N_CH-1:0]  fall_stb
);

  // Handshake: a write transfers on a clock edge where cfg_valid and
  // cfg_ready are both high. cfg_ready depends only on cfg_ch and the
  // target's pending flag (never on cfg_valid); it is low for a channel
  // whose shadow still waits for a boundary and for any cfg_ch >= N_CH.
  logic [N_CH-1:0] cfg_we;
  chan_cfg_t       cfg_new;

  assign cfg_new = cfg_sanitize(cfg_period, cfg_high, cfg_phase);

  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !cfg_pending[i];
    end
  end

  always_comb begin
    cfg_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    flash_clk_chan #(
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable[g]),
      .sync_restart (sync_restart),
      .cfg_we       (cfg_we[g]),
      .cfg_in       (cfg_new),
      .pending      (cfg_pending[g]),
      .flash_clk    (flash_clk[g]),
      .rise_stb     (rise_stb[g]),
      .fall_stb     (fall_stb[g])
    );
  end

endmodule

// File: tb/tb_flash_clk_gen.sv
// Self-checking bench for flash_clk_gen: waveforms are predicted from the
// period/high/phase formula and queued, then compared cycle by cycle.
module tb_flash_clk_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int CH_W  = $clog2(N_CH + 1);
  localparam int W     = 3 * N_CH;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  enable;
  logic             sync_restart;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period, cfg_high, cfg_phase;
  logic [N_CH-1:0]  cfg_pending, flash_clk, rise_stb, fall_stb;

  logic [W-1:0]     exp_q[$];
  logic [N_CH-1:0]  prev_out;
  logic [W-1:0]     e;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_clk_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(10), .DEF_HIGH(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_restart(sync_restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_pending(cfg_pending), .flash_clk(flash_clk),
    .rise_stb(rise_stb), .fall_stb(fall_stb)
  );

  // Output level on the n-th edge (n >= 1) after enable or restart.
  function automatic logic wave(int p, int h, int ph, int n);
    return ((ph + n - 1) % p) < h;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [N_CH-1:0] o);
    exp_q.push_back({o, ~prev_out & o, prev_out & ~o});
    prev_out = o;
  endtask

  task automatic drive_cfg(input int ch, input int p, input int h, input int ph);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_phase  = CNT_W'(ph);
  endtask

  task automatic reset_dut;
    reset        = 1'b1;
    enable       = '0;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_period   = '0;
    cfg_high     = '0;
    cfg_phase    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    prev_out = '0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = '0; sync_restart = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    #3;
    total++;
    if ({flash_clk, rise_stb, fall_stb, cfg_pending} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {flash_clk, rise_stb, fall_stb, cfg_pending});
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", cfg_ready);
    end
    reset_dut();
  endtask

  task automatic test_default_wave;
    reset_dut();
    enable = 4'b0001;
    for (int n = 1; n <= 25; n++) push_vec({3'b000, wave(10, 5, 0, n)});
    for (int n = 1; n <= 25; n++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({flash_clk, rise_stb, fall_stb} !== e) begin
        bad++;
        $display("FAIL default_wave n=%0d got=%h exp=%h", n, {flash_clk, rise_stb, fall_stb}, e);
      end
    end
  endtask

  task automatic test_cfg_pending;
    reset_dut();
    enable = 4'b0010;
    for (int n = 1; n <= 30; n++)
      push_vec({2'b00, (n <= 10) ? wave(10, 5, 0, n) : wave(8, 2, 0, n - 10), 1'b0});
    for (int n = 1; n <= 30; n++) begin
      if (n == 4) begin
        drive_cfg(1, 8, 2, 0);
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL pend_ready_before got=%b exp=1", cfg_ready);
        end
      end
      tick();
      if (n == 4) begin
        cfg_valid = 1'b0;
        #1;
        total++;
        if (cfg_pending !== 4'b0010 || cfg_ready !== 1'b0) begin
          bad++;
          $display("FAIL pend_after_accept pending=%b ready=%b exp=0010/0", cfg_pending, cfg_ready);
        end
      end
      if (n == 9 || n == 10) begin
        total++;
        if (cfg_pending !== ((n == 9) ? 4'b0010 : 4'b0000)) begin
          bad++;
          $display("FAIL pend_clear n=%0d got=%b", n, cfg_pending);
        end
      end
      e = exp_q.pop_front();
      total++;
      if ({flash_clk, rise_stb, fall_stb} !== e) begin
        bad++;
        $display("FAIL pend_wave n=%0d got=%h exp=%h", n, {flash_clk, rise_stb, fall_stb}, e);
      end
    end
  endtask

  task automatic test_coerce;
    int cp[3] = '{1, 6, 1};
    int ch[3] = '{1, 9, 0};
    int ep[3] = '{2, 6, 2};
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      enable = '0;
      drive_cfg(0, cp[k], ch[k], 0);
      tick();
      cfg_valid = 1'b0;
      total++;
      if (cfg_pending !== 4'b0001) begin
        bad++;
        $display("FAIL coerce_pend k=%0d got=%b exp=0001", k, cfg_pending);
      end
      tick();
      total++;
      if (cfg_pending !== 4'b0000) begin
        bad++;
        $display("FAIL coerce_apply k=%0d got=%b exp=0000", k, cfg_pending);
      end
      prev_out = '0;
      enable = 4'b0001;
      for (int n = 1; n <= 12; n++) push_vec({3'b000, wave(ep[k], ch[k], 0, n)});
      for (int n = 1; n <= 12; n++) begin
        tick();
        e = exp_q.pop_front();
        total++;
        if ({flash_clk, rise_stb, fall_stb} !== e) begin
          bad++;
          $display("FAIL coerce_wave k=%0d n=%0d got=%h exp=%h", k, n, {flash_clk, rise_stb, fall_stb}, e);
        end
      end
    end
  endtask

  task automatic test_sync_restart;
    reset_dut();
    drive_cfg(0, 10, 5, 0);
    tick();
    drive_cfg(2, 10, 5, 5);
    tick();
    cfg_valid = 1'b0;
    tick();
    enable = 4'b0101;
    repeat (7) tick();
    prev_out = 4'b0100;
    sync_restart = 1'b1;
    drive_cfg(0, 10, 2, 0);
    exp_q.push_back({4'b0000, 4'b0000, prev_out});
    prev_out = '0;
    tick();
    sync_restart = 1'b0;
    cfg_valid = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({flash_clk, rise_stb, fall_stb} !== e || cfg_pending !== 4'b0001) begin
      bad++;
      $display("FAIL sync_edge got=%h pend=%b exp=%h/0001", {flash_clk, rise_stb, fall_stb}, cfg_pending, e);
    end
    for (int n = 1; n <= 20; n++)
      push_vec({1'b0, wave(10, 5, 5, n), 1'b0,
                (n <= 10) ? wave(10, 5, 0, n) : wave(10, 2, 0, n - 10)});
    for (int n = 1; n <= 20; n++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({flash_clk, rise_stb, fall_stb} !== e) begin
        bad++;
        $display("FAIL sync_wave n=%0d got=%h exp=%h", n, {flash_clk, rise_stb, fall_stb}, e);
      end
      if (n == 10) begin
        total++;
        if (cfg_pending !== 4'b0000) begin
          bad++;
          $display("FAIL sync_pend_clear got=%b exp=0000", cfg_pending);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    reset_dut();
    enable = 4'b0011;
    repeat (3) tick();
    drive_cfg(1, 4, 1, 0);
    tick();
    cfg_valid = 1'b0;
    total++;
    if (cfg_pending !== 4'b0010 || flash_clk !== 4'b0011) begin
      bad++;
      $display("FAIL areset_pre pend=%b clk=%b exp=0010/0011", cfg_pending, flash_clk);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({flash_clk, rise_stb, fall_stb, cfg_pending} !== '0) begin
      bad++;
      $display("FAIL areset_immediate got=%h exp=0", {flash_clk, rise_stb, fall_stb, cfg_pending});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 4'b0010;
    prev_out = '0;
    for (int n = 1; n <= 20; n++) push_vec({2'b00, wave(10, 5, 0, n), 1'b0});
    for (int n = 1; n <= 20; n++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if ({flash_clk, rise_stb, fall_stb} !== e) begin
        bad++;
        $display("FAIL areset_default n=%0d got=%h exp=%h", n, {flash_clk, rise_stb, fall_stb}, e);
      end
    end
  endtask

  task automatic test_wrap_accept;
    reset_dut();
    enable = 4'b1000;
    for (int n = 1; n <= 32; n++)
      push_vec({(n <= 20) ? wave(10, 5, 0, n) : wave(4, 1, 0, n - 20), 3'b000});
    for (int n = 1; n <= 32; n++) begin
      if (n == 10) drive_cfg(3, 4, 1, 0);
      if (n == 25) begin
        drive_cfg(N_CH, 3, 1, 0);
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
          bad++;
          $display("FAIL bad_ch_ready got=%b exp=0", cfg_ready);
        end
      end
      tick();
      if (n == 10 || n == 25) cfg_valid = 1'b0;
      if (n == 10 || n == 19 || n == 20 || n == 25) begin
        total++;
        if (cfg_pending !== ((n == 10 || n == 19) ? 4'b1000 : 4'b0000)) begin
          bad++;
          $display("FAIL wrap_pend n=%0d got=%b", n, cfg_pending);
        end
      end
      e = exp_q.pop_front();
      total++;
      if ({flash_clk, rise_stb, fall_stb} !== e) begin
        bad++;
        $display("FAIL wrap_wave n=%0d got=%h exp=%h", n, {flash_clk, rise_stb, fall_stb}, e);
      end
    end
  endtask

  task automatic test_random;
    int c, p, h, ph, ps, phs;
    logic [N_CH-1:0] o;
    reset_dut();
    for (int it = 0; it < 6; it++) begin
      c  = $urandom_range(0, N_CH - 1);
      p  = $urandom_range(0, 12);
      h  = $urandom_range(0, 14);
      ph = $urandom_range(0, 14);
      ps  = (p < 2) ? 2 : p;
      phs = (ph >= ps) ? 0 : ph;
      enable = '0;
      drive_cfg(c, p, h, ph);
      tick();
      cfg_valid = 1'b0;
      tick();
      prev_out = '0;
      enable = N_CH'(1) << c;
      for (int n = 1; n <= 2 * ps + 3; n++) begin
        o = '0;
        o[c] = wave(ps, h, phs, n);
        push_vec(o);
      end
      for (int n = 1; n <= 2 * ps + 3; n++) begin
        tick();
        e = exp_q.pop_front();
        total++;
        if ({flash_clk, rise_stb, fall_stb} !== e) begin
          bad++;
          $display("FAIL random it=%0d ch=%0d cfg=%0d/%0d/%0d n=%0d got=%h exp=%h",
                   it, c, p, h, ph, n, {flash_clk, rise_stb, fall_stb}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_wave();
    test_cfg_pending();
    test_coerce();
    test_sync_restart();
    test_async_reset();
    test_wrap_accept();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
